alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Registered decode stage that turns a fetched 32-bit RV32I instruction into the operand-select and control fields consumed by the ALU: `optype`, `ALUOp`, `funct7`, register indices and immediate. It sits between fetch and execute as a single-entry ID/EX pipeline register with a valid/ready handshake on both sides and a synchronous flush. It decodes only OP (R-type) and OP-IMM (I-type) instructions; every other encoding is flagged illegal.

## Interface
- `XLEN`, default 32: datapath width; the immediate output is sign-extended to this width.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  fetch presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_instr`  in  32  raw instruction
- `in_pc`  in  XLEN  instruction address
- `flush`  in  1  discard the held entry and any entry accepted this cycle
- `out_valid`  out  1  decoded entry valid
- `out_ready`  in  1  execute consumes the entry
- `out_optype`  out  7  opcode, `instr[6:0]`
- `out_aluop`  out  3  ALU operation select
- `out_funct7`  out  7  funct7 qualifier for the ALU
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices
- `out_imm`  out  XLEN  immediate
- `out_use_imm`  out  1  second operand is `out_imm`
- `out_reg_write`  out  1  write `rd` at writeback
- `out_illegal`  out  1  unsupported encoding
- `out_pc`  out  XLEN  registered `in_pc`

## Operation
- ALUOp encodings: ADD_SUB=000, SLL=001, SLT=010, XOR=100, SRL_SRA=101, OR=110, AND=111. funct3=011 (SLTU/SLTIU) is illegal.
- **R-type** (opcode 0110011):
  - `aluop=instr[14:12]`, `funct7=instr[31:25]`, `use_imm=0`.
  - Legal funct7 is 0000000 for any legal funct3. 0100000 is also legal, but only with funct3 000 or 101.
- **I-type** (opcode 0010011):
  - `use_imm=1`, `aluop=instr[14:12]`, `rs2=0`.
  - Non-shift instructions: `imm` = sign-extended `instr[31:20]`, `funct7=0000000`.
  - funct3=001 (SLLI): requires `instr[31:25]=0000000`.
  - funct3=101: requires `instr[31:25]` to be 0000000 (SRLI) or 0100000 (SRAI).
  - Shifts: `funct7=instr[31:25]`, `imm={XLEN-5 zeros, instr[24:20]}`.
- **Illegal** (any other opcode, funct3=011, or a bad funct7):
  - `out_illegal=1`, `out_reg_write=0`, `aluop=000`, `funct7=0`, `imm=0`, `use_imm=0`.
  - `optype`, register indices and `pc` still pass through.
- `out_reg_write = legal && rd != 0`.
- Register fields `rs1=instr[19:15]`, `rs2=instr[24:20]` (R-type), `rd=instr[11:7]`.

## Timing
- Latency: exactly 1 cycle from acceptance to `out_valid`.
- `in_ready = !out_valid || out_ready`, combinational. Throughput is 1/cycle with no bubble under continuous flow.
- Accept occurs on `in_valid && in_ready`: all outputs load on that edge and `out_valid` is set.
- Consume without a new accept (`out_valid && out_ready`, no accept): `out_valid` clears.
- Stall (`out_valid && !out_ready`): every output holds bit-stable; `in_ready=0`.
- `flush`:
  - `out_valid` is 0 on the next edge.
  - `in_ready` is forced to 1 during flush. An instruction presented that cycle counts as accepted by upstream and is dropped.
  - Data outputs may take any value while `out_valid=0`.
  - Flush has priority over accept and stall.
- Reset (async assert, any time including mid-stall): `out_valid=0`, all data outputs 0, `in_ready=1`. Deassertion is synchronised by the system; the first accept can occur on the first edge after release.

## Test plan
- Reset mid-stall (held entry, `out_ready=0`, assert `rst_n=0`) -> `out_valid`=0 immediately, all outputs 0, `in_ready`=1.
- ADD x3,x1,x2 `0x002081B3`, then SUB x5,x6,x7 `0x407302B3` back-to-back with `out_ready=1` ->
  - Consecutive cycles: optype 0110011, aluop 000.
  - funct7 0000000 then 0100000.
  - rs1/rs2/rd 1/2/3 then 6/7/5; reg_write=1; no bubble.
- ADDI x1,x0,-1 `0xFFF00093` -> use_imm=1, imm `0xFFFFFFFF`, funct7 0, rd 1. SRAI x2,x2,3 `0x40315113` -> aluop 101, funct7 0100000, imm 3.
- SLTU `0x0020B1B3`, opcode 0000011, and R-type funct3=001 with funct7 0100000 -> illegal=1, reg_write=0, aluop 000; ADDI with rd=0 -> reg_write=0.
- Backpressure: hold `out_ready=0` for 3 cycles with `in_valid=1` -> `in_ready=0`, outputs stable. Release -> held entry consumed and next accepted on the same edge.
- Flush while stalled with `in_valid=1` -> `out_valid`=0 on the next cycle, incoming instruction dropped, `in_ready`=1 during flush.

Source files
------------

// File: rtl/alu_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for the ALU decode stage.
// master drives fetch-side inputs and the execute-side ready; slave is the stage itself.
interface alu_decode_stage_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [6:0]      out_optype;
    logic [2:0]      out_aluop;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_use_imm;
    logic            out_reg_write;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_optype, out_aluop, out_funct7,
               out_rs1, out_rs2, out_rd, out_imm, out_use_imm,
               out_reg_write, out_illegal, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_optype, out_aluop, out_funct7,
               out_rs1, out_rs2, out_rd, out_imm, out_use_imm,
               out_reg_write, out_illegal, out_pc
    );
endinterface

// File: rtl/alu_decode_stage.sv
// Purpose: RV32I OP/OP-IMM decode into ALU control fields, held in a single ID/EX register.
// Latency: 1 cycle from accept to out_valid; full throughput under continuous flow.
// Backpressure: in_ready = flush | !out_valid | out_ready; a stalled entry holds bit-stable.
module alu_decode_stage #(
    parameter int XLEN = 32
) (
    input logic               clk,
    input logic               rst_n,
    alu_decode_stage_if.slave bus
);
    localparam logic [6:0] OPC_REG = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [6:0]      optype;
        logic [2:0]      aluop;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            reg_write;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t     dec;
    entry_t     ent;
    logic       vld;
    logic       legal;
    logic       accept;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = bus.in_instr[6:0];
    assign f3     = bus.in_instr[14:12];
    assign f7     = bus.in_instr[31:25];

    always_comb begin
        legal = 1'b0;
        unique case (opcode)
            OPC_REG: legal = (f3 != 3'b011) &&
                             ((f7 == 7'd0) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
            OPC_IMM: begin
                unique case (f3)
                    3'b011:  legal = 1'b0;
                    3'b001:  legal = (f7 == 7'd0);
                    3'b101:  legal = (f7 == 7'd0) || (f7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        dec        = '0;
        dec.optype = opcode;
        dec.rs1    = bus.in_instr[19:15];
        dec.rs2    = (opcode == OPC_IMM) ? 5'd0 : bus.in_instr[24:20];
        dec.rd     = bus.in_instr[11:7];
        dec.pc     = bus.in_pc;
        if (legal) begin
            dec.aluop = f3;
            if (opcode == OPC_REG) begin
                dec.funct7 = f7;
            end else begin
                dec.use_imm = 1'b1;
                // Shift-immediates carry shamt in imm and the SRA/SRL qualifier in funct7.
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    dec.funct7 = f7;
                    dec.imm    = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
                end else begin
                    dec.imm    = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
                end
            end
        end
        dec.illegal   = !legal;
        dec.reg_write = legal && (bus.in_instr[11:7] != 5'd0);
    end

    assign bus.in_ready = bus.flush || !vld || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            ent <= '0;
        end else begin
            if (bus.flush)
                vld <= 1'b0;
            else if (accept)
                vld <= 1'b1;
            else if (bus.out_ready)
                vld <= 1'b0;
            // A flushed accept never loads, so the held entry stays put until refilled.
            if (accept && !bus.flush)
                ent <= dec;
        end
    end

    assign bus.out_valid     = vld;
    assign bus.out_optype    = ent.optype;
    assign bus.out_aluop     = ent.aluop;
    assign bus.out_funct7    = ent.funct7;
    assign bus.out_rs1       = ent.rs1;
    assign bus.out_rs2       = ent.rs2;
    assign bus.out_rd        = ent.rd;
    assign bus.out_imm       = ent.imm;
    assign bus.out_use_imm   = ent.use_imm;
    assign bus.out_reg_write = ent.reg_write;
    assign bus.out_illegal   = ent.illegal;
    assign bus.out_pc        = ent.pc;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed vector table, handshake corner sequences,
// and randomized traffic scored against an instruction-level reference queue.
module tb_alu_decode_stage;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    alu_decode_stage_if #(.XLEN(32)) bus ();
    alu_decode_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [6:0]  optype;
        logic [2:0]  aluop;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        reg_write;
        logic        illegal;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        exp_t        exp;
    } vec_t;

    function automatic exp_t mk(input logic [6:0] op, input logic [2:0] aluop, input logic [6:0] f7,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input logic use_imm, input logic rw,
                                input logic ill, input logic [31:0] pc);
        exp_t e;
        e = '{optype:op, aluop:aluop, funct7:f7, rs1:rs1, rs2:rs2, rd:rd, imm:imm,
              use_imm:use_imm, reg_write:rw, illegal:ill, pc:pc};
        return e;
    endfunction

    // Instruction-level meaning of OP / OP-IMM, expressed as legal encoding sets.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        int          op;
        int          f3;
        int          f7;
        bit          ok;
        logic [11:0] imm12;
        e     = '0;
        op    = int'(ins[6:0]);
        f3    = int'(ins[14:12]);
        f7    = int'(ins[31:25]);
        imm12 = ins[31:20];
        e.optype = ins[6:0];
        e.rs1    = ins[19:15];
        e.rd     = ins[11:7];
        e.rs2    = (op == 'h13) ? 5'd0 : ins[24:20];
        e.pc     = pc;
        if (op == 'h33)
            ok = (f7 == 0 && f3 != 3) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
        else if (op == 'h13)
            ok = (f3 inside {0, 2, 4, 6, 7}) || (f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 'h20));
        else
            ok = 1'b0;
        if (ok) begin
            e.aluop = ins[14:12];
            if (op == 'h33) begin
                e.funct7 = ins[31:25];
            end else begin
                e.use_imm = 1'b1;
                if (f3 == 1 || f3 == 5) begin
                    e.funct7 = ins[31:25];
                    e.imm    = 32'(ins[24:20]);
                end else begin
                    e.imm    = 32'($signed(imm12));
                end
            end
        end
        e.illegal   = !ok;
        e.reg_write = ok && (ins[11:7] != 5'd0);
        return e;
    endfunction

    function automatic exp_t observed();
        return mk(bus.out_optype, bus.out_aluop, bus.out_funct7, bus.out_rs1, bus.out_rs2,
                  bus.out_rd, bus.out_imm, bus.out_use_imm, bus.out_reg_write, bus.out_illegal,
                  bus.out_pc);
    endfunction

    task automatic check_entry(input string nm, input exp_t e);
        exp_t a;
        a = observed();
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k < 4)      r[6:0] = 7'b0110011;
        else if (k < 8) r[6:0] = 7'b0010011;
        k = $urandom_range(0, 3);
        if (k == 0)      r[31:25] = 7'b0000000;
        else if (k == 1) r[31:25] = 7'b0100000;
        return r;
    endfunction

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h407302B3;
    localparam logic [31:0] I_ADDI = 32'hFFF00093;

    vec_t tbl[8];
    exp_t exp_q[$];

    initial begin
        tbl[0] = '{"add",       I_ADD,        32'h1000, mk(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0,        1'b0, 1'b1, 1'b0, 32'h1000)};
        tbl[1] = '{"sub",       I_SUB,        32'h1004, mk(7'h33, 3'd0, 7'h20, 5'd6, 5'd7, 5'd5, 32'h0,        1'b0, 1'b1, 1'b0, 32'h1004)};
        tbl[2] = '{"addi_m1",   I_ADDI,       32'h1008, mk(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h1008)};
        tbl[3] = '{"srai",      32'h40315113, 32'h100C, mk(7'h13, 3'd5, 7'h20, 5'd2, 5'd0, 5'd2, 32'h3,        1'b1, 1'b1, 1'b0, 32'h100C)};
        tbl[4] = '{"sltu_ill",  32'h0020B1B3, 32'h1010, mk(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0,        1'b0, 1'b0, 1'b1, 32'h1010)};
        tbl[5] = '{"load_ill",  32'h0000A183, 32'h1014, mk(7'h03, 3'd0, 7'h00, 5'd1, 5'd0, 5'd3, 32'h0,        1'b0, 1'b0, 1'b1, 32'h1014)};
        tbl[6] = '{"sll20_ill", 32'h402091B3, 32'h1018, mk(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0,        1'b0, 1'b0, 1'b1, 32'h1018)};
        tbl[7] = '{"addi_rd0",  32'h00508013, 32'h101C, mk(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h5,        1'b1, 1'b0, 1'b0, 32'h101C)};

        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_bit("reset_out_valid", bus.out_valid, 1'b0);
        check_bit("reset_in_ready", bus.in_ready, 1'b1);
        check_entry("reset_outputs", '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table vectors, execute always ready: one entry per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].instr, tbl[i].pc, 1'b1, 1'b0);
            #1;
            check_bit({tbl[i].name, "_in_ready"}, bus.in_ready, 1'b1);
            step();
            check_bit({tbl[i].name, "_valid"}, bus.out_valid, 1'b1);
            check_entry(tbl[i].name, tbl[i].exp);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        check_bit("drain_valid", bus.out_valid, 1'b0);

        // Backpressure: three stalled cycles, then consume and accept on one edge.
        drive(1'b1, I_ADD, 32'h200, 1'b1, 1'b0);
        step();
        drive(1'b1, I_SUB, 32'h204, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check_bit("stall_in_ready", bus.in_ready, 1'b0);
            check_bit("stall_valid", bus.out_valid, 1'b1);
            check_entry("stall_hold", ref_decode(I_ADD, 32'h200));
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check_bit("release_in_ready", bus.in_ready, 1'b1);
        step();
        check_bit("release_valid", bus.out_valid, 1'b1);
        check_entry("release_next", ref_decode(I_SUB, 32'h204));
        bus.in_valid = 1'b0;
        step();
        check_bit("consume_clears", bus.out_valid, 1'b0);

        // Flush while stalled with a new instruction offered.
        drive(1'b1, I_ADD, 32'h300, 1'b1, 1'b0);
        step();
        drive(1'b1, I_SUB, 32'h304, 1'b0, 1'b1);
        #1;
        check_bit("flush_in_ready", bus.in_ready, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        check_bit("flush_valid", bus.out_valid, 1'b0);
        step();
        check_bit("flush_dropped", bus.out_valid, 1'b0);

        // Asynchronous reset while an entry is stalled.
        drive(1'b1, I_ADDI, 32'h400, 1'b1, 1'b0);
        step();
        drive(1'b1, I_SUB, 32'h404, 1'b0, 1'b0);
        step();
        check_entry("prereset_hold", ref_decode(I_ADDI, 32'h400));
        #1 rst_n = 1'b0;
        #1;
        check_bit("midrst_valid", bus.out_valid, 1'b0);
        check_bit("midrst_in_ready", bus.in_ready, 1'b1);
        check_entry("midrst_outputs", '0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, I_ADD, 32'h500, 1'b1, 1'b0);
        step();
        check_bit("post_reset_valid", bus.out_valid, 1'b1);
        check_entry("post_reset_accept", ref_decode(I_ADD, 32'h500));
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();

        // Randomized traffic: every accepted, unflushed instruction must appear once, in order.
        exp_q.delete();
        for (int n = 0; n < 600; n++) begin
            logic exp_rdy;
            logic consumed;
            logic accepted;
            drive($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
            #1;
            exp_rdy = bus.flush || (exp_q.size() == 0) || bus.out_ready;
            check_bit("rnd_in_ready", bus.in_ready, exp_rdy);
            check_bit("rnd_valid", bus.out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0 && bus.out_valid)
                check_entry("rnd_entry", exp_q[0]);
            consumed = (exp_q.size() != 0) && bus.out_ready;
            accepted = bus.in_valid && exp_rdy;
            if (bus.flush) begin
                exp_q.delete();
            end else begin
                if (consumed) void'(exp_q.pop_front());
                if (accepted) exp_q.push_back(ref_decode(bus.in_instr, bus.in_pc));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
